// File: rtl/down_timer_pkg.sv
// Shared types and defaults for the prescaled down-timer controller.
package down_timer_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_PRESC_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/down_timer_presc.sv
// Prescale counter: emits a tick once every (reload_val+1) enabled clocks.
module down_timer_presc
  import down_timer_pkg::*;
#(
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic [PRESC_W-1:0] load_val,
  input  logic [PRESC_W-1:0] reload_val,
  input  logic               en,
  output logic               tick
);

  localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] pre_cnt_q, pre_cnt_d;

  always_comb begin
    tick      = en && (pre_cnt_q == '0);
    pre_cnt_d = pre_cnt_q;
    if (clr) begin
      pre_cnt_d = '0;
    end else if (load) begin
      pre_cnt_d = load_val;
    end else if (tick) begin
      pre_cnt_d = reload_val;
    end else if (en) begin
      pre_cnt_d = pre_cnt_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/down_timer_ctrl.sv
// Programmable down-timer sequencer with pause, abort and auto-reload.
//   state | meaning
//   IDLE  | cleared, waiting for start
//   RUN   | counting at the prescaled rate
//   HOLD  | paused, count and prescaler frozen
//   DONE  | expired without reload, count parked at 0
module down_timer_ctrl
  import down_timer_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               auto_reload,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [PRESC_W-1:0] prescale,
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic               expired,
  output logic               done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   load_q, load_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               ar_q, ar_d;
  logic               expired_q, expired_d;

  logic active, accept, presc_en, tick;

  assign active = (state_q == S_RUN) || (state_q == S_HOLD);
  assign accept = start && !stop && ((state_q == S_IDLE) || (state_q == S_DONE));
  // HOLD with pause released counts this edge, so a pause of N cycles delays expiry by exactly N
  assign presc_en = active && !pause && !stop;

  down_timer_presc #(.PRESC_W(PRESC_W)) u_presc (
    .clk        (clk),
    .rst        (rst),
    .clr        (stop),
    .load       (accept),
    .load_val   (prescale),
    .reload_val (presc_q),
    .en         (presc_en),
    .tick       (tick)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    load_d    = load_q;
    presc_d   = presc_q;
    ar_d      = ar_q;
    expired_d = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      count_d = '0;
    end else if (accept) begin
      count_d = load_val;
      load_d  = load_val;
      presc_d = prescale;
      ar_d    = auto_reload;
      if (load_val != '0) begin
        state_d = S_RUN;
      end else begin
        state_d   = S_DONE;
        expired_d = 1'b1;
      end
    end else if (active) begin
      state_d = pause ? S_HOLD : S_RUN;
      if (tick) begin
        if (count_q > ONE) begin
          count_d = count_q - ONE;
        end else if (ar_q) begin
          count_d   = load_q;
          expired_d = 1'b1;
        end else begin
          count_d   = '0;
          expired_d = 1'b1;
          state_d   = S_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      load_q    <= '0;
      presc_q   <= '0;
      ar_q      <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      load_q    <= load_d;
      presc_q   <= presc_d;
      ar_q      <= ar_d;
      expired_q <= expired_d;
    end
  end

  assign count   = count_q;
  assign busy    = active;
  assign expired = expired_q;
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_down_timer_ctrl.sv
// Directed scoreboard bench: per-cycle expected outputs queued by the driver, checked by a monitor.
module tb_down_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       auto_reload = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] prescale = '0;
  logic [3:0] count;
  logic       busy, expired, done;

  typedef struct {
    int         id;
    logic [3:0] cnt;
    logic       busy;
    logic       exp;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  down_timer_ctrl #(.WIDTH(4), .PRESC_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .auto_reload (auto_reload),
    .load_val    (load_val),
    .prescale    (prescale),
    .count       (count),
    .busy        (busy),
    .expired     (expired),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Monitor: compare DUT outputs #1 after each edge against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (count !== e.cnt || busy !== e.busy || expired !== e.exp || done !== e.done) begin
        errors++;
        $display("FAIL step%0d got cnt=%0d busy=%b exp=%b done=%b want cnt=%0d busy=%b exp=%b done=%b",
                 e.id, count, busy, expired, done, e.cnt, e.busy, e.exp, e.done);
      end
    end
  end

  // One clock edge with the inputs currently driven; start/stop/rst are single-cycle pulses.
  task automatic cyc(input logic [3:0] c, input logic b, input logic x, input logic d);
    exp_t e;
    @(posedge clk);
    e.id = step_id; e.cnt = c; e.busy = b; e.exp = x; e.done = d;
    exp_q.push_back(e);
    step_id++;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic go(input logic [3:0] lv, input logic [3:0] ps, input logic ar);
    start = 1'b1; load_val = lv; prescale = ps; auto_reload = ar;
  endtask

  initial begin
    @(negedge clk);
    // 1: reset, then 5 with prescale 0
    rst = 1'b1; cyc(0, 0, 0, 0);
    rst = 1'b1; cyc(0, 0, 0, 0);
    go(5, 0, 0); cyc(5, 1, 0, 0);
    cyc(4, 1, 0, 0); cyc(3, 1, 0, 0); cyc(2, 1, 0, 0); cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    // 2: restart from DONE, 3 with prescale 2
    go(3, 2, 0); cyc(3, 1, 0, 0);
    cyc(3, 1, 0, 0); cyc(3, 1, 0, 0);
    cyc(2, 1, 0, 0); cyc(2, 1, 0, 0); cyc(2, 1, 0, 0);
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    // 3: auto-reload 4; a start mid-run is ignored; stop aborts
    go(4, 0, 1); cyc(4, 1, 0, 0);
    cyc(3, 1, 0, 0); cyc(2, 1, 0, 0); cyc(1, 1, 0, 0);
    cyc(4, 1, 1, 0);
    go(9, 3, 0); cyc(3, 1, 0, 0);
    cyc(2, 1, 0, 0); cyc(1, 1, 0, 0);
    cyc(4, 1, 1, 0);
    cyc(3, 1, 0, 0);
    stop = 1'b1; cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    // 4: 6 with a 3-cycle pause at count 3
    go(6, 0, 0); cyc(6, 1, 0, 0);
    cyc(5, 1, 0, 0); cyc(4, 1, 0, 0); cyc(3, 1, 0, 0);
    pause = 1'b1; cyc(3, 1, 0, 0); cyc(3, 1, 0, 0); cyc(3, 1, 0, 0);
    pause = 1'b0; cyc(2, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    // 5: stop+start together in RUN resolves to stop; then load 0 expires at once
    go(6, 0, 0); cyc(6, 1, 0, 0);
    cyc(5, 1, 0, 0); cyc(4, 1, 0, 0);
    go(7, 0, 0); stop = 1'b1; cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    go(0, 0, 0); cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    // 6: reset with start mid-run at count 2, prescale 1
    go(5, 1, 0); cyc(5, 1, 0, 0);
    cyc(5, 1, 0, 0); cyc(4, 1, 0, 0); cyc(4, 1, 0, 0);
    cyc(3, 1, 0, 0); cyc(3, 1, 0, 0); cyc(2, 1, 0, 0);
    rst = 1'b1; go(5, 1, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    // 7: pause already high on the start edge, then stop from DONE
    pause = 1'b1; go(2, 0, 0); cyc(2, 1, 0, 0);
    cyc(2, 1, 0, 0);
    pause = 1'b0; cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 1);
    stop = 1'b1; cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
